bcd_display_scanner: RTL and testbench

Time-multiplexed four-digit seven-segment driver that consumes the four BCD digits (thousand, hundred, ten, one) produced by the binary-to-BCD converter and scans them onto a common-anode display. Digits are double-buffered so that a new value takes effect only at a frame boundary, which prevents tearing. Each digit slot begins with an anti-ghosting blank interval. The block sits between the converter and the board display pins.

---
 rtl/bcd_display_pkg.sv | 15 +
 rtl/bcd_to_seven_segment.sv | 15 +
 rtl/bcd_display_scanner.sv | 94 +++++++++
 tb/tb_bcd_display_scanner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: shared constants, digit index type and segment table for the BCD display scanner
package bcd_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef logic [1:0] digit_idx_t;

    // Active-low {g,f,e,d,c,b,a} codes for digits 0..9
    localparam logic [6:0] SEG_CODES [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/bcd_to_seven_segment.sv
// bcd_to_seven_segment: combinational BCD digit to active-low seven-segment code with blank override
module bcd_to_seven_segment
    import bcd_display_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Blank wins; values 10..15 are not BCD and show a dash
    always_comb begin
        seg_o = blank_i ? SEG_BLANK : (digit_i < 4'd10) ? SEG_CODES[digit_i] : SEG_DASH;
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: double-buffered four-digit multiplexed seven-segment driver (option: LEADING_ZERO_BLANK_EN)
module bcd_display_scanner
    import bcd_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clock_i,
    input  logic       resetn_i,
    input  logic       load_i,
    input  logic [3:0] thousand_i,
    input  logic [3:0] hundred_i,
    input  logic [3:0] ten_i,
    input  logic [3:0] one_i,
    output logic [6:0] seg_o,
    output logic [3:0] anode_o,
    output logic       frame_done_o
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    digit_idx_t    idx_q, idx_d;
    logic [15:0]   act_q, act_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    anode_q, anode_d;
    logic          frame_done_q;

    logic          slot_end;
    logic          boundary;
    logic [15:0]   load_val;
    logic [3:0]    digit;
    logic [3:0]    lz_mask;
    logic          blank;

    // Scan timing, double-buffer update and the next output word
    always_comb begin
        slot_end = cnt_q == CW'(REFRESH_DIV - 1);
        boundary = slot_end && idx_q == 2'd3;
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = slot_end ? idx_q + 1'b1 : idx_q;
        load_val = {thousand_i, hundred_i, ten_i, one_i};
        pend_d   = (load_i && !boundary) ? load_val : pend_q;
        pend_v_d = load_i ? !boundary : (boundary ? 1'b0 : pend_v_q);
        act_d    = (load_i && boundary) ? load_val : (boundary && pend_v_q) ? pend_q : act_q;
        digit    = act_q[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        lz_mask  = {act_q[15:12] == 4'd0,
                    act_q[15:8] == 8'd0,
                    act_q[15:4] == 12'd0,
                    1'b0};
`else
        lz_mask  = 4'b0000;
`endif
        blank    = (cnt_q < CW'(BLANK_CYCLES)) || lz_mask[idx_q];
        anode_d  = blank ? 4'hF : ~(4'b0001 << idx_q);
    end

    bcd_to_seven_segment u_dec (
        .digit_i (digit),
        .blank_i (blank),
        .seg_o   (seg_d)
    );

    // State and registered outputs; reset discards any pending load
    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            act_q        <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            seg_q        <= SEG_BLANK;
            anode_q      <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            seg_q        <= seg_d;
            anode_q      <= anode_d;
            frame_done_q <= boundary;
        end
    end

    assign seg_o        = seg_q;
    assign anode_o      = anode_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: scoreboard bench for bcd_display_scanner against a time-based display model
module tb_bcd_display_scanner;

    localparam int R  = 8;
    localparam int B  = 2;
    localparam int FR = 4 * R;

    localparam logic [6:0] SEGS [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] anode;
        logic       fd;
    } out_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       load = 1'b0;
    logic [3:0] th = '0, hu = '0, te = '0, on = '0;
    logic [6:0] seg;
    logic [3:0] anode;
    logic       frame_done;

    out_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;

    int   t = 0;
    int   disp[4] = '{default: 0};
    int   pend[4] = '{default: 0};
    bit   have_pend = 0;

    always #5 clk = ~clk;

    bcd_display_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clock_i      (clk),
        .resetn_i     (resetn),
        .load_i       (load),
        .thousand_i   (th),
        .hundred_i    (hu),
        .ten_i        (te),
        .one_i        (on),
        .seg_o        (seg),
        .anode_o      (anode),
        .frame_done_o (frame_done)
    );

    task automatic model_step();
        int   idx, off, d;
        bit   bnd, blank, lead;
        out_t e;
        if (!resetn) begin
            e = {7'h7F, 4'hF, 1'b0};
            t = 0;
            disp = '{default: 0};
            pend = '{default: 0};
            have_pend = 0;
        end else begin
            idx   = (t / R) % 4;
            off   = t % R;
            bnd   = (t % FR) == FR - 1;
            d     = disp[idx];
            blank = off < B;
`ifdef LEADING_ZERO_BLANK_EN
            if (idx > 0) begin
                lead = 1;
                for (int k = idx; k < 4; k++) if (disp[k] != 0) lead = 0;
                blank = blank || lead;
            end
`endif
            e.fd    = bnd;
            e.anode = blank ? 4'hF : 4'(15 - (1 << idx));
            e.seg   = blank ? 7'h7F : (d < 10) ? SEGS[d] : 7'h3F;
            if (load) begin
                if (bnd) begin
                    disp = '{int'(on), int'(te), int'(hu), int'(th)};
                    have_pend = 0;
                end else begin
                    pend = '{int'(on), int'(te), int'(hu), int'(th)};
                    have_pend = 1;
                end
            end else if (bnd && have_pend) begin
                disp = pend;
                have_pend = 0;
            end
            t++;
        end
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                compared++;
                if ({seg, anode, frame_done} !== e) begin
                    mismatched++;
                    $display("FAIL out @%0t: got seg=%h anode=%h fd=%b, want seg=%h anode=%h fd=%b",
                             $time, seg, anode, frame_done, e.seg, e.anode, e.fd);
                end
            end
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(int a, int b, int c, int d);
        th = 4'(a); hu = 4'(b); te = 4'(c); on = 4'(d);
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic wait_phase(int p);
        int k = 0;
        while ((t % FR) != p && k < 2 * FR) begin
            cyc();
            k++;
        end
        if ((t % FR) != p) begin
            compared++;
            mismatched++;
            $display("FAIL wait_phase: got phase %0d, want %0d", t % FR, p);
        end
    endtask

    function automatic int rnd_digit();
        return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
    endfunction

    initial begin
        resetn = 1'b0;
        cyc(3);
        resetn = 1'b1;
        cyc(FR + 5);
        wait_phase(10);
        do_load(1, 2, 3, 4);
        cyc(2 * FR);
        wait_phase(FR - 1);
        do_load(5, 6, 7, 8);
        cyc(FR + 4);
        wait_phase(5);
        do_load(9, 9, 9, 9);
        cyc(7);
        do_load(0, 0, 0, 7);
        cyc(2 * FR);
        wait_phase(3);
        do_load(12, 0, 0, 0);
        cyc(2 * FR);
        repeat (40) begin
            if ($urandom_range(0, 3) == 0) wait_phase(FR - 1);
            else cyc(int'($urandom_range(0, 40)));
            do_load(rnd_digit(), rnd_digit(), rnd_digit(), rnd_digit());
        end
        cyc(2 * FR);
        wait_phase(9);
        do_load(3, 3, 3, 3);
        wait_phase(2 * R + 4);
        resetn = 1'b0;
        th = 4'd6; hu = 4'd6; te = 4'd6; on = 4'd6;
        load = 1'b1;
        cyc(2);
        load = 1'b0;
        resetn = 1'b1;
        cyc(3 * FR);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
